// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Write-back arbiter for the register file write port. Merges
//               single-cycle ALU results with load returns, buffers loads
//               that lose arbitration, and tracks pending loads so decode
//               can stall on load-use / WAW hazards.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_alu_valid,
  input  logic [4:0]      i_alu_rd,
  input  logic [XLEN-1:0] i_alu_data,
  input  logic            i_ld_issue,
  input  logic [4:0]      i_ld_issue_rd,
  input  logic            i_ld_valid,
  output logic            o_ld_ready,
  input  logic [4:0]      i_ld_rd,
  input  logic [XLEN-1:0] i_ld_data,
  input  logic [4:0]      i_chk_rs1,
  input  logic [4:0]      i_chk_rs2,
  input  logic [4:0]      i_chk_rd,
  output logic            o_hazard,
  output logic            o_wb_en,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_busy
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] c_FULL = CW'(DEPTH);

  // Load-return buffer storage (no reset needed: validity is tracked by count)
  logic [4:0]      r_buf_rd   [DEPTH];
  logic [XLEN-1:0] r_buf_data [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic [31:0]     r_pending;
  logic            r_wb_en;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;

  logic            w_empty;
  logic            w_ld_acc;
  logic            w_pop;
  logic            w_bypass;
  logic            w_push;
  logic            w_ld_write;
  logic [4:0]      w_wr_rd;
  logic [XLEN-1:0] w_wr_data;
  logic            w_wr_en;
  logic [31:0]     w_pend_nxt;

  // Ready depends only on the pre-pop count, so a full buffer refuses even if it pops this cycle
  assign o_ld_ready = ~i_rst & (r_count != c_FULL);
  assign w_empty    = (r_count == '0);
  assign w_ld_acc   = i_ld_valid & o_ld_ready;
  assign w_pop      = ~i_alu_valid & ~w_empty;
  assign w_bypass   = w_ld_acc & ~i_alu_valid & w_empty;
  assign w_push     = w_ld_acc & ~w_bypass;
  assign w_ld_write = w_pop | w_bypass;

  // Write-port source select: ALU, then buffer head, then direct load return
  always_comb begin
    w_wr_rd   = i_ld_rd;
    w_wr_data = i_ld_data;
    if (i_alu_valid) begin
      w_wr_rd   = i_alu_rd;
      w_wr_data = i_alu_data;
    end else if (w_pop) begin
      w_wr_rd   = r_buf_rd[r_rd_ptr];
      w_wr_data = r_buf_data[r_rd_ptr];
    end
    w_wr_en = (i_alu_valid | w_ld_write) & (w_wr_rd != 5'd0);
  end

  // Scoreboard update: clear on a load write, set on issue; set wins on conflict
  always_comb begin
    w_pend_nxt = r_pending;
    if (w_ld_write) begin
      w_pend_nxt[w_wr_rd] = 1'b0;
    end
    if (i_ld_issue) begin
      w_pend_nxt[i_ld_issue_rd] = 1'b1;
    end
    w_pend_nxt[0] = 1'b0;
  end

  // Buffer payload write at the tail
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_buf_rd[r_wr_ptr]   <= i_ld_rd;
      r_buf_data[r_wr_ptr] <= i_ld_data;
    end
  end

  // Buffer pointers, occupancy and scoreboard state
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_pending <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count   <= r_count + CW'(w_push) - CW'(w_pop);
      r_pending <= w_pend_nxt;
    end
  end

  // Registered write port; rd/data hold their last value when no write occurs
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wb_en   <= 1'b0;
      r_wb_rd   <= 5'd0;
      r_wb_data <= '0;
    end else begin
      r_wb_en <= w_wr_en;
      if (w_wr_en) begin
        r_wb_rd   <= w_wr_rd;
        r_wb_data <= w_wr_data;
      end
    end
  end

  assign o_wb_en   = r_wb_en;
  assign o_wb_rd   = r_wb_rd;
  assign o_wb_data = r_wb_data;
  assign o_hazard  = r_pending[i_chk_rs1] | r_pending[i_chk_rs2] | r_pending[i_chk_rd];
  assign o_busy    = (r_count != '0) | (|r_pending);

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Directed self-checking bench for wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_issue;
  logic [4:0]  ld_issue_rd;
  logic        ld_valid;
  logic        ld_ready;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic [4:0]  chk_rs1, chk_rs2, chk_rd;
  logic        hazard;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  wb_arbiter #(.DEPTH(2), .XLEN(32)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_alu_valid  (alu_valid),
    .i_alu_rd     (alu_rd),
    .i_alu_data   (alu_data),
    .i_ld_issue   (ld_issue),
    .i_ld_issue_rd(ld_issue_rd),
    .i_ld_valid   (ld_valid),
    .o_ld_ready   (ld_ready),
    .i_ld_rd      (ld_rd),
    .i_ld_data    (ld_data),
    .i_chk_rs1    (chk_rs1),
    .i_chk_rs2    (chk_rs2),
    .i_chk_rd     (chk_rd),
    .o_hazard     (hazard),
    .o_wb_en      (wb_en),
    .o_wb_rd      (wb_rd),
    .o_wb_data    (wb_data),
    .o_busy       (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sample point is 1 time unit after the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string tag, input logic en, input logic [4:0] rd, input logic [31:0] d);
    chk({tag, ".en"}, 32'(wb_en), 32'(en));
    chk({tag, ".rd"}, 32'(wb_rd), 32'(rd));
    chk({tag, ".data"}, wb_data, d);
  endtask

  initial begin
    rst = 1'b1; alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hAAAA_AAAA;
    ld_issue = 1'b0; ld_issue_rd = 5'd0; ld_valid = 1'b0; ld_rd = 5'd0; ld_data = 32'd0;
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

    // Reset held two cycles with ALU activity
    tick(); tick();
    chk_wb("reset", 1'b0, 5'd0, 32'd0);
    chk("reset.ld_ready", 32'(ld_ready), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.hazard", 32'(hazard), 32'd0);
    rst = 1'b0; alu_valid = 1'b0;
    #1;
    chk("release.ld_ready", 32'(ld_ready), 32'd1);

    // ALU write, then ALU to x0 (no write, values held)
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    tick();
    chk_wb("alu5", 1'b1, 5'd5, 32'hDEAD_BEEF);
    alu_rd = 5'd0; alu_data = 32'h0000_0055;
    tick();
    chk_wb("alu0", 1'b0, 5'd5, 32'hDEAD_BEEF);
    alu_valid = 1'b0;
    tick();

    // Load issue marks rd 7 pending; bypass return clears it
    ld_issue = 1'b1; ld_issue_rd = 5'd7; chk_rs1 = 5'd7;
    tick();
    ld_issue = 1'b0;
    #1;
    chk("issue7.hazard", 32'(hazard), 32'd1);
    chk("issue7.busy", 32'(busy), 32'd1);
    tick();
    chk("issue7.hold", 32'(hazard), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd7; ld_data = 32'h0000_1234;
    #1;
    chk("bypass.ld_ready", 32'(ld_ready), 32'd1);
    tick();
    ld_valid = 1'b0;
    #1;
    chk_wb("bypass7", 1'b1, 5'd7, 32'h0000_1234);
    chk("bypass7.hazard", 32'(hazard), 32'd0);
    chk("bypass7.busy", 32'(busy), 32'd0);
    chk_rs1 = 5'd0;

    // Collision: four ALU writes while loads 8,9,10 return
    ld_issue = 1'b1; ld_issue_rd = 5'd8; tick();
    ld_issue_rd = 5'd9; tick();
    ld_issue_rd = 5'd10; tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hA1;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h108;
    #1; chk("col0.ld_ready", 32'(ld_ready), 32'd1);
    tick(); chk_wb("col.alu1", 1'b1, 5'd1, 32'hA1);
    alu_rd = 5'd2; alu_data = 32'hA2; ld_rd = 5'd9; ld_data = 32'h109;
    #1; chk("col1.ld_ready", 32'(ld_ready), 32'd1);
    tick(); chk_wb("col.alu2", 1'b1, 5'd2, 32'hA2);
    alu_rd = 5'd3; alu_data = 32'hA3; ld_rd = 5'd10; ld_data = 32'h10A;
    #1; chk("col2.ld_ready", 32'(ld_ready), 32'd0);
    tick(); chk_wb("col.alu3", 1'b1, 5'd3, 32'hA3);
    alu_rd = 5'd4; alu_data = 32'hA4;
    #1; chk("col3.ld_ready", 32'(ld_ready), 32'd0);
    tick(); chk_wb("col.alu4", 1'b1, 5'd4, 32'hA4);
    alu_valid = 1'b0; chk_rs1 = 5'd8;
    #1;
    chk("col4.ld_ready", 32'(ld_ready), 32'd0);
    chk("col4.hazard", 32'(hazard), 32'd1);
    tick(); chk_wb("col.ld8", 1'b1, 5'd8, 32'h108);
    chk("col5.ld_ready", 32'(ld_ready), 32'd1);
    tick(); ld_valid = 1'b0;
    chk_wb("col.ld9", 1'b1, 5'd9, 32'h109);
    tick(); chk_wb("col.ld10", 1'b1, 5'd10, 32'h10A);
    chk_rs2 = 5'd9; chk_rd = 5'd10;
    #1;
    chk("col.hazard_clr", 32'(hazard), 32'd0);
    chk("col.busy_clr", 32'(busy), 32'd0);
    tick(); chk("col.idle_en", 32'(wb_en), 32'd0);
    chk_rs1 = 5'd0; chk_rs2 = 5'd0; chk_rd = 5'd0;

    // Set/clear race on rd 3
    ld_issue = 1'b1; ld_issue_rd = 5'd3; tick();
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h33; chk_rs2 = 5'd3;
    tick();
    ld_issue = 1'b0; ld_valid = 1'b0;
    #1;
    chk_wb("race.wb", 1'b1, 5'd3, 32'h33);
    chk("race.hazard", 32'(hazard), 32'd1);
    tick();
    chk("race.hazard_hold", 32'(hazard), 32'd1);
    ld_valid = 1'b1; ld_rd = 5'd3; ld_data = 32'h34;
    tick(); ld_valid = 1'b0;
    #1;
    chk("race.hazard_clr", 32'(hazard), 32'd0);

    // Load to x0 consumes its turn without writing
    ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 32'h99;
    tick(); ld_valid = 1'b0;
    chk_wb("ld0", 1'b0, 5'd3, 32'h34);
    chk_rs2 = 5'd0;

    // Reset mid-flight with two buffered loads
    ld_issue = 1'b1; ld_issue_rd = 5'd8; tick();
    ld_issue_rd = 5'd9; tick();
    ld_issue = 1'b0;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB1;
    ld_valid = 1'b1; ld_rd = 5'd8; ld_data = 32'h208;
    tick();
    alu_rd = 5'd12; alu_data = 32'hB2; ld_rd = 5'd9; ld_data = 32'h209;
    tick();
    ld_valid = 1'b0; alu_valid = 1'b0;
    #1;
    chk("mid.full", 32'(ld_ready), 32'd0);
    chk("mid.busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; chk_rs1 = 5'd8; chk_rs2 = 5'd9;
    #1;
    chk("mid.rst_en", 32'(wb_en), 32'd0);
    chk("mid.rst_busy", 32'(busy), 32'd0);
    chk("mid.rst_ready", 32'(ld_ready), 32'd1);
    chk("mid.rst_hazard", 32'(hazard), 32'd0);
    tick(); chk("mid.after1_en", 32'(wb_en), 32'd0);
    tick(); chk("mid.after2_en", 32'(wb_en), 32'd0);
    chk("mid.after2_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter.md
# wb_arbiter

Write-back arbiter: the single writer of the register file write port (the rd/data/write-enable inputs of the 32x32 register file). It merges single-cycle ALU results with out-of-order-latency load returns, buffers loads that lose arbitration, and keeps a pending-load scoreboard so decode can stall on load-use and WAW hazards. It sits between the execute/load units and the register file, and is the producer side of that write interface.

## Interface

- DEPTH, 2, load-return buffer entries (power of two, ≥2)
- XLEN, 32, data width

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset; one clock, reset is synchronous and active-high
- alu_valid  in  1  ALU result valid this cycle (no backpressure, always accepted)
- alu_rd  in  5  ALU destination register
- alu_data  in  XLEN  ALU result
- ld_issue  in  1  load issued this cycle; marks ld_issue_rd pending
- ld_issue_rd  in  5  issuing load's destination
- ld_valid  in  1  load return valid
- ld_ready  out  1  load return accepted when ld_valid & ld_ready
- ld_rd  in  5  load return destination
- ld_data  in  XLEN  load return data
- chk_rs1, chk_rs2, chk_rd  in  5 each  decode-stage registers to check
- hazard  out  1  combinational: any chk_* register is pending
- wb_en  out  1  register-file write enable (registered)
- wb_rd  out  5  register-file destination (registered)
- wb_data  out  XLEN  register-file write data (registered)
- busy  out  1  buffer non-empty or any register pending

## Operation

- One write per cycle. Priority: ALU > buffer head > direct load return.
- ALU: alu_valid with alu_rd≠0 → wb_en=1, wb_rd=alu_rd, wb_data=alu_data next cycle. alu_rd=0 → no write (wb_en=0), nothing else changes.
- Load return accepted when ld_ready=1; ld_ready = buffer not full (combinational from registered count, independent of ld_valid).
- Accepted load: if alu_valid=0 and buffer empty → written directly (bypass). Otherwise pushed to buffer tail. Buffer pops head whenever alu_valid=0 and buffer non-empty; the same-cycle incoming load is then pushed (push and pop in one cycle allowed, also when full-then-pop? No: ld_ready uses pre-pop count, so a full buffer refuses).
- Load with ld_rd=0: accepted, consumes its slot/turn, wb_en stays 0.
- Scoreboard: 32-bit pending vector; bit 0 constant 0.
  - Set bit ld_issue_rd on ld_issue (ld_issue_rd≠0).
  - Clear bit wb_rd when a load write is selected (bypass or pop), at the same edge wb_* is loaded.
  - Same-cycle set and clear of one bit: set wins.
- hazard = pending[chk_rs1] | pending[chk_rs2] | pending[chk_rd]. Upstream must stall on hazard; an ALU write to a pending rd is a protocol violation (not checked).
- busy = (count≠0) | (|pending).

## Timing

- Reset (sync, sampled on clock edge): wb_en=0, wb_rd=0, wb_data=0, pending=0, buffer empty (count=0, pointers 0), ld_ready=0 while reset high, 1 the cycle after, hazard=0, busy=0.
- Reset mid-operation discards buffered loads and all pending bits; no write is issued in the reset cycle's successor.
- Latency: ALU and bypass load → wb_* one cycle after the input cycle. Buffered load → one cycle after the first cycle with alu_valid=0 at buffer head.
- wb_en is a one-cycle pulse per write; wb_rd/wb_data hold last value when wb_en=0.
- Buffer pointers wrap modulo DEPTH; count width log2(DEPTH)+1.
- Scoreboard clear is visible on hazard the cycle after the write edge (same cycle wb_en=1 is seen by the register file).

## Test plan

- Reset: assert reset 2 cycles with alu_valid=1 → wb_en=0, wb_rd=0, wb_data=0, ld_ready=0, busy=0; ld_ready=1 after release.
- ALU only: alu_rd=5, alu_data=0xDEADBEEF → next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF; alu_rd=0 → wb_en=0.
- Load bypass + scoreboard: ld_issue rd=7, chk_rs1=7 → hazard=1 next cycle; later ld_valid rd=7 data=0x1234 with no ALU → wb rd=7 data=0x1234 next cycle, hazard=0 one cycle later.
- Collision/buffering: alu_valid 4 consecutive cycles (rd=1..4) while loads rd=8,9,10 return → loads 8,9 buffered, ld_ready=0 on third, ALU writes 1..4 in order, then 8,9,10 in order; no write lost.
- Set/clear race: load for rd=3 written in same cycle as new ld_issue rd=3 → pending[3] stays 1, hazard on chk_rs2=3 remains 1.
- Reset mid-flight: buffer holding 2 loads, pending={8,9}, assert reset → count=0, pending=0, no wb_en pulse afterwards, busy=0.
